// File: rtl/gate_sweep_pkg.sv
// Shared constants for the gate sweep checker: FSM state encoding and
// parameter limits enforced by the top module at elaboration.
package gate_sweep_pkg;

  localparam int MAX_N_IN   = 6;
  localparam int MAX_SETTLE = 15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic state_is_busy(input logic [1:0] st);
    return (st == ST_DRIVE) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/gate_sweep_checker_settle_timer.sv
// Loadable 4-bit down-counter; expired while the count sits at zero, so a
// load of SETTLE-1 yields SETTLE cycles before expiry.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // NOTE: the default assignment at the top of always_comb keeps every path
  // assigned, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 4'd0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps every input combination of a combinational gate in ascending order,
// compares each response with TRUTH and records mismatch count / first failure.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter logic [2**N_IN-1:0]  TRUTH  = 4'b0111,
  parameter int                  SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  generate
    if (N_IN < 1 || N_IN > MAX_N_IN || SETTLE < 1 || SETTLE > MAX_SETTLE) begin : g_param_guard
      $error("gate_sweep_checker: N_IN must be 1..%0d and SETTLE 1..%0d", MAX_N_IN, MAX_SETTLE);
    end
  endgenerate

  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE     = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE     = {{N_IN{1'b0}}, 1'b1};
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [N_IN:0]   fail_count_q, fail_count_d;
  logic            ff_valid_q, ff_valid_d;
  logic [N_IN-1:0] ff_vec_q, ff_vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic timer_load;
  logic timer_expired;
  logic mismatch;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    fail_count_d = fail_count_q;
    ff_valid_d   = ff_valid_q;
    ff_vec_d     = ff_vec_q;
    timer_load   = 1'b0;
    // Case inequality so an X or Z from the gate is a failure, not a pass.
    mismatch     = (dut_out !== TRUTH[stim_q]);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          stim_d       = '0;
          fail_count_d = '0;
          ff_valid_d   = 1'b0;
          ff_vec_d     = '0;
          timer_load   = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (timer_expired) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          fail_count_d = fail_count_q + CNT_ONE;
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_vec_d   = stim_q;
          end
        end
        if (stim_q == LAST_VEC) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_DRIVE;
          stim_d     = stim_q + VEC_ONE;
          timer_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are decoded from the next state so they leave flops too.
    busy_d = state_is_busy(state_d);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (fail_count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stim_q       <= '0;
      fail_count_q <= '0;
      ff_valid_q   <= 1'b0;
      ff_vec_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      fail_count_q <= fail_count_d;
      ff_valid_q   <= ff_valid_d;
      ff_vec_q     <= ff_vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_count_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: stimulus pushes the expected sweep outcome, monitors pop
// and compare when done rises; stim walk and flag exclusivity checked per cycle.
module tb_gate_sweep_checker;

  localparam logic [3:0] TRUTH_A  = 4'b0111;
  localparam int         S_A      = 1;
  localparam logic [7:0] TRUTH_B  = 8'b1000_0000;
  localparam int         S_B      = 3;

  typedef struct {
    int fails;
    int ffv;
    int ffvec;
    int pass_;
    int t0;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default NAND2 configuration
  logic       start_a = 1'b0;
  logic [1:0] stim_a;
  logic       dut_out_a, busy_a, done_a, pass_a, ffv_a;
  logic [2:0] fails_a;
  logic [1:0] ffvec_a;
  logic [3:0] flip_a = '0;
  int         xvec_a = -1;

  assign dut_out_a = (xvec_a == int'(stim_a)) ? 1'bx
                   : (~(stim_a[1] & stim_a[0]) ^ flip_a[stim_a]);

  gate_sweep_checker u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fails_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  // Instance B: AND3 with a 3-cycle settle
  logic       start_b = 1'b0;
  logic [2:0] stim_b;
  logic       dut_out_b, busy_b, done_b, pass_b, ffv_b;
  logic [3:0] fails_b;
  logic [2:0] ffvec_b;
  logic [7:0] flip_b = '0;

  assign dut_out_b = (&stim_b) ^ flip_b[stim_b];

  gate_sweep_checker #(.N_IN(3), .TRUTH(TRUTH_B), .SETTLE(S_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fails_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  exp_t qa[$];
  exp_t qb[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Outcome of one sweep from the rules: every vector where the gate's answer
  // differs from the table (or is unknown) is a failure.
  function automatic exp_t model(input int n, input int settle, input logic [63:0] truth,
                                 input logic [63:0] gate, input int xvec, input int t0);
    exp_t e;
    e.fails = 0; e.ffv = 0; e.ffvec = 0;
    for (int i = 0; i < (1 << n); i++) begin
      if (i == xvec || gate[i] != truth[i]) begin
        if (e.fails == 0) begin
          e.ffv   = 1;
          e.ffvec = i;
        end
        e.fails++;
      end
    end
    e.pass_    = (e.fails == 0) ? 1 : 0;
    e.t0       = t0;
    e.done_cyc = t0 + (1 << n) * (settle + 1);
    return e;
  endfunction

  // Monitor A
  logic done_prev_a = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    check("excl_a", int'(busy_a & done_a), 0);
    check("pass_wo_done_a", int'(pass_a & ~done_a), 0);
    if (busy_a) begin
      if (qa.size() == 0) check("busy_unexpected_a", qa.size(), 1);
      else check("stim_walk_a", int'(stim_a), (cyc - qa[0].t0) / (S_A + 1));
    end
    if (done_a && !done_prev_a) begin
      if (qa.size() == 0) begin
        check("done_unexpected_a", qa.size(), 1);
      end else begin
        e = qa.pop_front();
        check("done_latency_a", cyc, e.done_cyc);
        check("fail_count_a", int'(fails_a), e.fails);
        check("ff_valid_a", int'(ffv_a), e.ffv);
        check("ff_vec_a", int'(ffvec_a), e.ffvec);
        check("pass_a", int'(pass_a), e.pass_);
      end
    end
    done_prev_a = done_a;
  end

  // Monitor B
  logic done_prev_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    check("excl_b", int'(busy_b & done_b), 0);
    check("pass_wo_done_b", int'(pass_b & ~done_b), 0);
    if (busy_b) begin
      if (qb.size() == 0) check("busy_unexpected_b", qb.size(), 1);
      else check("stim_walk_b", int'(stim_b), (cyc - qb[0].t0) / (S_B + 1));
    end
    if (done_b && !done_prev_b) begin
      if (qb.size() == 0) begin
        check("done_unexpected_b", qb.size(), 1);
      end else begin
        e = qb.pop_front();
        check("done_latency_b", cyc, e.done_cyc);
        check("fail_count_b", int'(fails_b), e.fails);
        check("ff_valid_b", int'(ffv_b), e.ffv);
        check("ff_vec_b", int'(ffvec_b), e.ffvec);
        check("pass_b", int'(pass_b), e.pass_);
      end
    end
    done_prev_b = done_b;
  end

  task automatic check_idle_a();
    check("rst_stim_a", int'(stim_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_pass_a", int'(pass_a), 0);
    check("rst_fails_a", int'(fails_a), 0);
    check("rst_ffv_a", int'(ffv_a), 0);
    check("rst_ffvec_a", int'(ffvec_a), 0);
  endtask

  task automatic check_idle_b();
    check("rst_stim_b", int'(stim_b), 0);
    check("rst_busy_b", int'(busy_b), 0);
    check("rst_done_b", int'(done_b), 0);
    check("rst_pass_b", int'(pass_b), 0);
    check("rst_fails_b", int'(fails_b), 0);
    check("rst_ffv_b", int'(ffv_b), 0);
    check("rst_ffvec_b", int'(ffvec_b), 0);
  endtask

  task automatic push_start_a(input logic [3:0] flip, input int xvec, output exp_t e);
    logic [63:0] g = '0;
    for (int i = 0; i < 4; i++) g[i] = (i != 3) ^ flip[i];
    @(negedge clk);
    flip_a = flip;
    xvec_a = xvec;
    e = model(2, S_A, 64'(TRUTH_A), g, xvec, cyc + 1);
    qa.push_back(e);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic run_a(input logic [3:0] flip, input int xvec, input bit mid_start);
    exp_t e;
    int   k = 0;
    push_start_a(flip, xvec, e);
    if (mid_start) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    while (qa.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (qa.size() != 0) begin
      check("timeout_a", qa.size(), 0);
      qa.delete();
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    check("hold_done_a", int'(done_a), 1);
    check("hold_fails_a", int'(fails_a), e.fails);
  endtask

  task automatic run_b(input logic [7:0] flip, input bit mid_start);
    exp_t        e;
    logic [63:0] g = '0;
    int          k = 0;
    for (int i = 0; i < 8; i++) g[i] = (i == 7) ^ flip[i];
    @(negedge clk);
    flip_b = flip;
    e = model(3, S_B, 64'(TRUTH_B), g, -1, cyc + 1);
    qb.push_back(e);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    if (mid_start) begin
      repeat ($urandom_range(1, 25)) @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
    end
    while (qb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (qb.size() != 0) begin
      check("timeout_b", qb.size(), 0);
      qb.delete();
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    check("hold_done_b", int'(done_b), 1);
    check("hold_fails_b", int'(fails_b), e.fails);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_a();
    check_idle_b();

    // Directed sweeps on the default NAND2 instance
    run_a(4'b0000, -1, 1'b0);   // correct gate
    run_a(4'b1000, -1, 1'b0);   // output forced to 1 at stim=3
    run_a(4'b0111, -1, 1'b0);   // stuck at 0
    run_a(4'b0000,  1, 1'b0);   // unknown output at stim=1
    run_a(4'b0000, -1, 1'b1);   // spurious start mid-run

    // Reset during DRIVE of stim=2, with start held across the reset edge
    push_start_a(4'b0000, -1, e);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (!(busy_a && stim_a == 2'd2) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("reach_stim2_a", int'(stim_a), 2);
    rst     = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    start_a = 1'b0;
    qa.delete();
    check_idle_a();
    repeat (2) @(negedge clk);
    check("stay_idle_a", int'(busy_a), 0);
    run_a(4'b0000, -1, 1'b0);

    // Randomised fault patterns on instance A
    for (int i = 0; i < 20; i++) begin
      run_a(4'($urandom_range(0, 15)), -1, 1'($urandom_range(0, 1)));
    end

    // AND3 with SETTLE=3: correct gate, then random faults
    run_b(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_b(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Synthesizable self-checking sweep stage that wraps a combinational gate under test. It sits upstream of the gate, driving every input combination in ascending order, and downstream of it, comparing each output against a parameterized truth table. It counts mismatches and records the first failing vector, replacing hand-written per-vector assertion sequences.

## Interface
- `N_IN`, default 2: number of gate inputs; legal range 1..6.
- `TRUTH`, default 4'b0111 (NAND): expected output table, `2**N_IN` bits wide. Bit `i` is the expected output for stimulus value `i`.
- `SETTLE`, default 1: cycles each vector is held before it is sampled; legal range 1..15.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep; sampled only in IDLE or DONE.
- `stim`  out  N_IN  vector driven to the gate; bit `N_IN-1` is the first operand (`a`).
- `dut_out`  in  1  gate output.
- `busy`  out  1  high in DRIVE and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `fail_count == 0`.
- `fail_count`  out  N_IN+1  number of mismatching vectors in the current or last sweep.
- `first_fail_valid`  out  1  set at the first mismatch of a sweep.
- `first_fail_vec`  out  N_IN  stimulus of the first mismatch.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE, or DONE, with `start` high:
  - Clear `fail_count`, `first_fail_valid`, `first_fail_vec` and the settle counter.
  - Set `stim` to 0.
  - Go to DRIVE.
- DRIVE: hold `stim`. Increment the settle counter. When the counter reaches `SETTLE-1`, go to CHECK.
- CHECK: compare `dut_out` with `TRUTH[stim]` using case inequality, so X or Z counts as a mismatch.
  - On mismatch, increment `fail_count`.
  - If `first_fail_valid` is 0 on a mismatch, set it and capture `stim` into `first_fail_vec`.
  - If `stim == 2**N_IN-1`, go to DONE and leave `stim` unchanged.
  - Otherwise, increment `stim`, clear the settle counter, and go to DRIVE.
- DONE: hold all results. `start` restarts the sweep as in IDLE.
- `start` is ignored in DRIVE and CHECK. A sweep cannot be aborted except by `rst`.
- `fail_count` width is `N_IN+1`, so it holds a count of `2**N_IN` without wrapping.
- The `stim` increment is plain binary. Wrap-around never occurs because the last vector exits to DONE.

## Timing
- Reset values: state IDLE, `stim` 0, `busy` 0, `done` 0, `pass` 0, `fail_count` 0, `first_fail_valid` 0, `first_fail_vec` 0.
- `rst` asserted in any state, including mid-sweep, returns all of the above on the next edge. `rst` has priority over `start`.
- Start latency: `start` high at edge k gives `busy`=1 and `stim`=0 after edge k.
- Each vector occupies `SETTLE` DRIVE cycles plus 1 CHECK cycle.
- `done` rises after edge k + `2**N_IN*(SETTLE+1)`. With the defaults, that is edge k+8.
- `pass` and `done` change on the same edge.
- `busy` and `done` are never high together.
- All outputs are registered. There are no combinational paths from `dut_out` or `start` to any output.

## Structure
- Shared package `gate_sweep_pkg` holds:
  - state encoding constants IDLE=0, DRIVE=1, CHECK=2, DONE=3;
  - the `MAX_N_IN`=6 and `MAX_SETTLE`=15 limits, checked by an elaboration-time guard in the top module.
- One sub-module: `settle_timer`, a 4-bit loadable down-counter.
  - Inputs: `clk`, `rst`, `load`, `load_val`.
  - Output: `expired`.
- The top module holds the FSM, the stimulus register and the result registers.

## Test plan
- Defaults; `dut_out` driven by a correct NAND of `stim[1]`,`stim[0]`; pulse `start` -> `done`=1 and `pass`=1 exactly 8 cycles later, `fail_count`=0, `first_fail_valid`=0.
- Defaults; the NAND output is forced to 1 for `stim`=3 -> `fail_count`=1, `first_fail_vec`=2'b11, `pass`=0.
- Defaults; `dut_out` stuck at 0 -> `fail_count`=3 and `first_fail_vec`=2'b00.
- `rst` asserted for 1 cycle during the DRIVE phase of `stim`=2 -> the next cycle shows IDLE, all outputs 0, and `start` pulses during the run were ignored. A fresh `start` then completes in 8 cycles.
- `N_IN`=3, `TRUTH`=8'b1000_0000 (AND3), `SETTLE`=3 with a correct AND3 -> `done` 32 cycles after `start`, `pass`=1, and `stim` walks 0..7, each value held 4 cycles.
- `dut_out`=1'bx at `stim`=1 with defaults -> counted as a mismatch, `first_fail_vec`=2'b01.
